// File: rtl/conv3x3_window_if.sv
// Pixel-stream bus for the 3x3 convolution window: pixel input, kernel/shift
// controls, and the result stream with its progress status.
interface conv3x3_window_if;
    logic [7:0]  pix_in;
    logic        pix_vld;
    logic [71:0] kern;
    logic [3:0]  shift;
    logic [7:0]  pix_out;
    logic        out_vld;
    logic [19:0] out_cnt;
    logic        done;

    modport master (
        output pix_in, pix_vld, kern, shift,
        input  pix_out, out_vld, out_cnt, done
    );

    modport slave (
        input  pix_in, pix_vld, kern, shift,
        output pix_out, out_vld, out_cnt, done
    );
endinterface

// File: rtl/conv3x3_window.sv
// Streaming 3x3 convolution over a raster image: two line buffers feed a sliding
// window, then a registered multiply stage and a sum/shift/clamp stage.
module conv3x3_window #(
    parameter int unsigned IMG_W = 502,
    parameter int unsigned IMG_H = 502
) (
    input logic             clk,
    input logic             rst,
    conv3x3_window_if.slave bus
);

    localparam int unsigned CW    = $clog2(IMG_W);
    localparam int unsigned RW    = $clog2(IMG_H);
    localparam logic [19:0] TOTAL = 20'((IMG_W - 2) * (IMG_H - 2));

    // Input position tracking
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          full_q, full_d;
    logic          accept;

    // Capture of the accepted pixel, consumed by the line buffers/window next cycle
    logic [7:0]    in_pix_q;
    logic [CW-1:0] in_col_q;
    logic          in_vld_q;
    logic          in_win_q, in_win_d;

    logic [7:0] lb0_mem [IMG_W];
    logic [7:0] lb1_mem [IMG_W];
    logic [7:0] lb0_rd, lb1_rd;

    // Window index k = 3*row + col, row 0 oldest line, col 0 oldest column
    logic [7:0] win_q [9];
    logic [7:0] win_d [9];
    logic       win_vld_q;

    logic signed [16:0] prod_q [9];
    logic signed [16:0] prod_d [9];
    logic               s1_vld_q;

    logic signed [20:0] sum;
    logic signed [20:0] shifted;
    logic [7:0]         clamped;

    logic [7:0]  pix_out_q, pix_out_d;
    logic        out_vld_q;
    logic [19:0] out_cnt_q, out_cnt_d;
    logic        done_q, done_d;

    // Once the last pixel of the frame is in, further pixels are ignored until reset.
    assign accept = bus.pix_vld && !full_q && !done_q;

    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        full_d = full_q;
        if (accept) begin
            if (col_q == CW'(IMG_W - 1)) begin
                col_d = '0;
                if (row_q == RW'(IMG_H - 1)) begin
                    full_d = 1'b1;
                end else begin
                    row_d = row_q + RW'(1);
                end
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    assign in_win_d = accept && (row_q >= RW'(2)) && (col_q >= CW'(2));

    assign lb0_rd = lb0_mem[in_col_q];
    assign lb1_rd = lb1_mem[in_col_q];

    // Line buffers: read-before-write at the same column; no reset needed.
    always_ff @(posedge clk) begin
        if (in_vld_q) begin
            lb0_mem[in_col_q] <= in_pix_q;
            lb1_mem[in_col_q] <= lb0_rd;
        end
    end

    always_comb begin
        win_d = win_q;
        if (in_vld_q) begin
            for (int r = 0; r < 3; r++) begin
                win_d[3*r]     = win_q[3*r+1];
                win_d[3*r + 1] = win_q[3*r+2];
            end
            win_d[2] = lb1_rd;
            win_d[5] = lb0_rd;
            win_d[8] = in_pix_q;
        end
    end

    // Pixels are zero-extended so that 255 stays positive in the signed product.
    always_comb begin
        for (int k = 0; k < 9; k++) begin
            prod_d[k] = 17'($signed({1'b0, win_q[k]})) * 17'($signed(bus.kern[8*k +: 8]));
        end
    end

    always_comb begin
        sum = '0;
        for (int k = 0; k < 9; k++) begin
            sum = sum + {{4{prod_q[k][16]}}, prod_q[k]};
        end
        shifted = sum >>> bus.shift;
        if (shifted < 21'sd0) begin
            clamped = 8'd0;
        end else if (shifted > 21'sd255) begin
            clamped = 8'hff;
        end else begin
            clamped = shifted[7:0];
        end
    end

    always_comb begin
        pix_out_d = pix_out_q;
        out_cnt_d = out_cnt_q;
        if (s1_vld_q) begin
            pix_out_d = clamped;
            out_cnt_d = out_cnt_q + 20'd1;
        end
        done_d = done_q || (out_vld_q && (out_cnt_q == TOTAL));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            col_q     <= '0;
            row_q     <= '0;
            full_q    <= 1'b0;
            in_pix_q  <= '0;
            in_col_q  <= '0;
            in_vld_q  <= 1'b0;
            in_win_q  <= 1'b0;
            win_vld_q <= 1'b0;
            s1_vld_q  <= 1'b0;
            pix_out_q <= '0;
            out_vld_q <= 1'b0;
            out_cnt_q <= '0;
            done_q    <= 1'b0;
            for (int k = 0; k < 9; k++) begin
                win_q[k]  <= '0;
                prod_q[k] <= '0;
            end
        end else begin
            col_q     <= col_d;
            row_q     <= row_d;
            full_q    <= full_d;
            in_vld_q  <= accept;
            in_win_q  <= in_win_d;
            if (accept) begin
                in_pix_q <= bus.pix_in;
                in_col_q <= col_q;
            end
            win_vld_q <= in_win_q;
            s1_vld_q  <= win_vld_q;
            pix_out_q <= pix_out_d;
            out_vld_q <= s1_vld_q;
            out_cnt_q <= out_cnt_d;
            done_q    <= done_d;
            for (int k = 0; k < 9; k++) begin
                win_q[k]  <= win_d[k];
                prod_q[k] <= prod_d[k];
            end
        end
    end

    assign bus.pix_out = pix_out_q;
    assign bus.out_vld = out_vld_q;
    assign bus.out_cnt = out_cnt_q;
    assign bus.done    = done_q;

endmodule

// File: doc/conv3x3_window.md
CONV3X3_WINDOW -- requirements
Module: conv3x3_window

Interface
REQ-001 Parameter IMG_W, default 502, pixels per image row; legal range 3..1023.
REQ-002 Parameter IMG_H, default 502, rows per image; legal range 3..1023.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset: synchronous, active-low.
REQ-005 pix_in  input  8  unsigned pixel byte, raster order, from the UART receive stage.
REQ-006 pix_vld  input  1  one-cycle qualifier per pixel; may be high on consecutive cycles.
REQ-007 kern  input  72  nine signed 8-bit coefficients; bits [8k+7:8k] = k, k = 3*row+col, row 0 = oldest line.
REQ-008 shift  input  4  right-shift normalisation, 0..15.
REQ-009 pix_out  output  8  convolution result, clamped unsigned.
REQ-010 out_vld  output  1  one-cycle qualifier for pix_out.
REQ-011 out_cnt  output  20  results emitted since reset.
REQ-012 done  output  1  high once the final result of the frame is emitted.

Function
REQ-013 Input col counter 0..IMG_W-1 and row counter 0..IMG_H-1 advance only on pix_vld; col wraps to 0 and row increments at col = IMG_W-1.
REQ-014 Two line buffers of IMG_W bytes hold the previous two rows; each is read and written at the same col address in the pix_vld cycle (read-before-write).
REQ-015 A 3x3 window register shifts one column left per pix_vld; new right column = {line buf 1, line buf 0, pix_in}, oldest at top.
REQ-016 Window is valid when the accepted pixel has row >= 2 and col >= 2; results cover the interior only: (IMG_W-2)*(IMG_H-2) outputs per frame.
REQ-017 Stage 1 forms nine signed products pixel (zero-extended to 9 bits) x coefficient, registered as 17-bit signed values.
REQ-018 Stage 2 sums the nine products into a 21-bit signed total, arithmetic right-shifts by shift, clamps to 0..255 and registers into pix_out.
REQ-019 kern and shift are sampled in the stage that uses them; changes mid-frame apply to pixels entering that stage afterwards.
REQ-020 Latency: out_vld rises exactly 3 rising edges after the edge that sampled the qualifying pix_vld (window, stage 1, stage 2), for a throughput of 1 result per cycle.
REQ-021 Gaps in pix_vld insert no bubbles in in-flight results; the pipeline advances every cycle and carries a valid bit.
REQ-022 out_cnt increments together with each out_vld; it does not wrap within a frame.
REQ-023 done goes high in the cycle after the final out_vld (out_cnt = (IMG_W-2)*(IMG_H-2)) and stays high until reset.
REQ-024 pix_vld while done is high, or after row IMG_H-1 col IMG_W-1 has been accepted, is ignored; counters, buffers and outputs are unchanged.
REQ-025 pix_out holds its last value while out_vld is low.

Reset
REQ-026 With rst low at a rising edge: col, row, out_cnt = 0; pix_out = 0; out_vld = 0; done = 0; all pipeline valid bits = 0; window registers = 0.
REQ-027 Line buffer contents need no reset; every window position is rewritten before it is consumed.
REQ-028 Reset mid-frame discards in-flight results (no out_vld after the reset edge); the next pix_vld is treated as row 0 col 0.

Verification
REQ-029 IMG_W=5, IMG_H=4, kern centre=1 and others 0, shift=0, pixels 0..19 back-to-back -> 6 results 6,7,8,11,12,13; first out_vld 3 edges after pixel 12 is accepted; done after the 6th.
REQ-030 Constant 80 image, all coefficients 1, shift=3 -> every pix_out = 90 (720>>3).
REQ-031 Constant 200 image, all coefficients 1, shift=0 -> pix_out = 255 (clamp high); centre -1 and others 0 -> pix_out = 0 (clamp low).
REQ-032 Default 502x502 ramp image with random 0-5 cycle gaps in pix_vld, compared against a reference model -> exactly 250000 matching results, done set, out_cnt = 250000.
REQ-033 Reset asserted after 100 accepted pixels, then a fresh 5x4 frame -> no stale out_vld; results identical to REQ-029.
REQ-034 Extra pix_vld pulses after done -> no out_vld, out_cnt unchanged.
